vlc_bit_packer: RTL and testbench

- Parametrised variable-length code packer for the Huffman encoder output path.
- Accepts one MSB-aligned code of 0..W bits per beat and packs codes back-to-back, first bit into the output MSB, into OW-bit words.
- Adds a valid/ready handshake on both sides, an explicit flush with a configurable pad bit, and an emitted-word counter.
- Sits between the Huffman code lookup and the output memory or stream interface.

---
 rtl/vlc_bit_packer.sv | 128 ++++++++++++
 tb/tb_vlc_bit_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vlc_bit_packer.sv
// Variable-length code packer: appends MSB-aligned codes of 0..W bits back-to-back
// into OW-bit output words, with valid/ready on both sides and a padded flush.
module vlc_bit_packer #(
    parameter int W   = 8,
    parameter int C   = 4,
    parameter int OW  = 8,
    parameter bit PAD = 1'b0,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  d_in,
    input  logic [C-1:0]  w_in,
    input  logic          en_in,
    output logic          rdy_in,
    input  logic          flush_in,
    output logic [OW-1:0] d_out,
    output logic          en_out,
    input  logic          out_rdy,
    output logic          flush_done,
    output logic [CW-1:0] word_cnt
);

    localparam int AW = OW + W;
    localparam int FW = $clog2(AW + 1);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [FW-1:0] fill;

    logic [FW-1:0] len;
    logic [FW-1:0] base;
    logic [FW-1:0] fill_next;
    logic [W-1:0]  code_mask;
    logic [AW-1:0] code_wide;
    logic [AW-1:0] acc_next;
    logic [OW-1:0] word_next;
    logic          accept;
    logic          out_free;
    logic          extract;
    logic          pad_load;
    logic          load_word;

    // Holding fill at or below OW leaves room for a full W-bit code.
    assign rdy_in = (state == RUN) && (fill <= FW'(OW));

    always_comb begin
        // NOTE: every signal gets a default at the top so no path can infer a latch.
        len       = '0;
        base      = fill;
        fill_next = fill;
        acc_next  = acc;
        word_next = acc[AW-1 -: OW];

        if (int'(w_in) > W) len = FW'(W);
        else                len = FW'(w_in);

        accept   = en_in && rdy_in;
        out_free = !en_out || out_rdy;
        extract  = (state != DRAIN) && (fill >= FW'(OW)) && out_free;
        pad_load = (state == FLUSH) && (fill != '0) && (fill < FW'(OW)) && out_free;

        code_mask = ~({W{1'b1}} >> len);
        code_wide = {d_in & code_mask, {OW{1'b0}}};

        if (extract) begin
            acc_next = acc << OW;
            base     = fill - FW'(OW);
        end
        // Bits below fill are always zero, so OR-ing places the new code exactly.
        if (accept) acc_next = acc_next | (code_wide >> base);
        fill_next = base + (accept ? len : '0);

        if (pad_load) begin
            word_next = acc[AW-1 -: OW] | (PAD ? ({OW{1'b1}} >> fill) : '0);
            acc_next  = '0;
            fill_next = '0;
        end

        load_word = extract || pad_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the accumulator is reset too; stale bits would otherwise leak into the next word.
            acc        <= '0;
            fill       <= '0;
            d_out      <= '0;
            en_out     <= 1'b0;
            flush_done <= 1'b0;
            word_cnt   <= '0;
            state      <= RUN;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            acc        <= acc_next;
            fill       <= fill_next;
            flush_done <= 1'b0;

            if (load_word) begin
                d_out  <= word_next;
                en_out <= 1'b1;
            end else if (en_out && out_rdy) begin
                en_out <= 1'b0;
            end

            if (en_out && out_rdy) word_cnt <= word_cnt + CW'(1);

            case (state)
                RUN: begin
                    if (flush_in) state <= FLUSH;
                end
                FLUSH: begin
                    if ((fill == '0) || pad_load) state <= DRAIN;
                end
                DRAIN: begin
                    if (out_free) begin
                        flush_done <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed bench for vlc_bit_packer (W=8, OW=8, C=4, PAD=0): hand-computed words,
// stall behaviour, flush, clamping and reset.
module tb_vlc_bit_packer;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int OW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  d_in;
    logic [C-1:0]  w_in;
    logic          en_in;
    logic          rdy_in;
    logic          flush_in;
    logic [OW-1:0] d_out;
    logic          en_out;
    logic          out_rdy;
    logic          flush_done;
    logic [CW-1:0] word_cnt;

    int tests_run = 0;
    int fails     = 0;
    int fd_cnt    = 0;
    int fd_words  = -1;
    int accepted  = 0;
    logic [OW-1:0] got[$];

    always #5 clk = ~clk;

    vlc_bit_packer #(.W(W), .C(C), .OW(OW), .PAD(1'b0), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .w_in       (w_in),
        .en_in      (en_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .d_out      (d_out),
        .en_out     (en_out),
        .out_rdy    (out_rdy),
        .flush_done (flush_done),
        .word_cnt   (word_cnt)
    );

    // Inputs change only at posedge+1, so a handshake seen here completes at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (en_out && out_rdy) got.push_back(d_out);
            if (flush_done) begin
                fd_cnt++;
                fd_words = got.size();
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic [C-1:0] w);
        int n = 0;
        d_in  = d;
        w_in  = w;
        en_in = 1'b1;
        @(negedge clk);
        while (!rdy_in && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rdy_wait", 32'(rdy_in), 32'd1);
        @(posedge clk);
        #1;
        en_in = 1'b0;
        accepted++;
    endtask

    task automatic pulse_flush();
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("word_wait", 32'(got.size()), 32'(n));
    endtask

    task automatic wait_flush(input int n, input int budget);
        int k = 0;
        while (fd_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("flush_wait", 32'(fd_cnt), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; d_in = '0; w_in = '0; en_in = 1'b0; flush_in = 1'b0; out_rdy = 1'b1;
        #1;
        check("rst_d_out", 32'(d_out), 32'h0);
        check("rst_en_out", 32'(en_out), 32'h0);
        check("rst_word_cnt", 32'(word_cnt), 32'h0);
        check("rst_flush_done", 32'(flush_done), 32'h0);
        settle(2);
        rst = 1'b0;
        settle(1);
        check("idle_rdy_in", 32'(rdy_in), 32'd1);

        // Eight 2-bit codes 00,01,... -> 0x11, 0x11
        got.delete(); fd_cnt = 0;
        for (int i = 0; i < 8; i++) send((i % 2 == 1) ? 8'h40 : 8'h00, 4'd2);
        wait_words(2, 20);
        settle(2);
        check("t1_word0", got_at(0), 32'h11);
        check("t1_word1", got_at(1), 32'h11);
        check("t1_cnt", 32'(word_cnt), 32'd2);
        check("t1_no_flush", 32'(fd_cnt), 32'd0);

        // Eight 3-bit codes 100,101,... -> 0x96, 0x59, 0x65
        got.delete();
        for (int i = 0; i < 8; i++) send((i % 2 == 1) ? 8'hA0 : 8'h80, 4'd3);
        wait_words(3, 20);
        settle(2);
        check("t2_word0", got_at(0), 32'h96);
        check("t2_word1", got_at(1), 32'h59);
        check("t2_word2", got_at(2), 32'h65);
        check("t2_cnt", 32'(word_cnt), 32'd5);

        // Three 111 codes then flush -> 0xFF, 0x80 (zero padded), one flush_done after 0x80
        got.delete(); fd_cnt = 0; fd_words = -1;
        for (int i = 0; i < 3; i++) send(8'hE0, 4'd3);
        pulse_flush();
        wait_flush(1, 20);
        settle(3);
        check("t3_nwords", 32'(got.size()), 32'd2);
        check("t3_word0", got_at(0), 32'hFF);
        check("t3_word1", got_at(1), 32'h80);
        check("t3_fd_once", 32'(fd_cnt), 32'd1);
        check("t3_fd_after_word", 32'(fd_words), 32'd2);
        check("t3_fd_low", 32'(flush_done), 32'd0);
        check("t3_rdy_back", 32'(rdy_in), 32'd1);
        check("t3_cnt", 32'(word_cnt), 32'd7);

        // Flush with nothing buffered: flush_done, no word
        got.delete(); fd_cnt = 0;
        pulse_flush();
        wait_flush(1, 4);
        settle(3);
        check("t3e_fd_once", 32'(fd_cnt), 32'd1);
        check("t3e_no_word", 32'(got.size()), 32'd0);
        check("t3e_cnt", 32'(word_cnt), 32'd7);

        // Sixteen 2-bit 11 codes with downstream stalled: 9 beats fit, then four 0xFF words
        got.delete(); accepted = 0; out_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(8'hC0, 4'd2);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (rdy_in && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("t4_rdy_drop", 32'(rdy_in), 32'd0);
                check("t4_accepted", 32'(accepted), 32'd9);
                check("t4_out_full", 32'(en_out), 32'd1);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check("t4_hold_d_out", 32'(d_out), 32'hFF);
                    check("t4_hold_rdy", 32'(rdy_in), 32'd0);
                end
                check("t4_none_out", 32'(got.size()), 32'd0);
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_words(4, 50);
        settle(3);
        check("t4_nwords", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t4_word", got_at(i), 32'hFF);
        check("t4_cnt", 32'(word_cnt), 32'd11);

        // Zero-length beats with junk interleaved, junk low bits, then an over-long length
        got.delete();
        for (int i = 0; i < 8; i++) begin
            send((i % 2 == 1) ? 8'hBF : 8'h9F, 4'd3);
            send(8'hFF, 4'd0);
        end
        send(8'hAB, 4'd12);
        wait_words(4, 20);
        settle(2);
        check("t5_word0", got_at(0), 32'h96);
        check("t5_word1", got_at(1), 32'h59);
        check("t5_word2", got_at(2), 32'h65);
        check("t5_clamp", got_at(3), 32'hAB);
        check("t5_cnt", 32'(word_cnt), 32'd15);

        // Reset with 5 bits buffered, then a clean 8-bit code
        send(8'hF8, 4'd5);
        rst = 1'b1;
        #1;
        check("t6_d_out", 32'(d_out), 32'h0);
        check("t6_en_out", 32'(en_out), 32'h0);
        check("t6_cnt", 32'(word_cnt), 32'h0);
        check("t6_fd", 32'(flush_done), 32'h0);
        settle(2);
        rst = 1'b0;
        got.delete();
        settle(1);
        send(8'h3C, 4'd8);
        check("t6_latency_pre", 32'(en_out), 32'd0);
        settle(1);
        check("t6_latency_en", 32'(en_out), 32'd1);
        check("t6_latency_d", 32'(d_out), 32'h3C);
        settle(2);
        check("t6_nwords", 32'(got.size()), 32'd1);
        check("t6_word", got_at(0), 32'h3C);
        check("t6_cnt_after", 32'(word_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
